// File: rtl/draw_cmd_writer.sv
// Painter command-queue producer: turns one rectangle-fill or buffer-swap request
// into per-line two-word span records, stalling on queue back-pressure.
module draw_cmd_writer #(
  parameter int unsigned LINES  = 120,
  parameter int unsigned COLS   = 160,
  parameter int unsigned LINE_W = 7,
  parameter int unsigned COL_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_swap,
  input  logic [LINE_W-1:0] req_top,
  input  logic [LINE_W-1:0] req_bottom,
  input  logic [COL_W-1:0]  req_left,
  input  logic [COL_W-1:0]  req_right,
  input  logic [2:0]        req_color,
  output logic              q_we,
  output logic [15:0]       q_data,
  input  logic              q_full,
  output logic              busy,
  output logic              cmd_done,
  output logic              cmd_drop,
  output logic [15:0]       span_count
);

  localparam logic [LINE_W-1:0] LAST_LINE  = LINE_W'(LINES - 1);
  localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(COLS - 1);
  localparam logic [15:0]       SWAP_WORD0 = 16'h0000;
  localparam logic [15:0]       SWAP_WORD1 = 16'h0008;

  typedef enum logic [1:0] {IDLE, WORD0, WORD1} state_t;

  state_t            state, next_state;
  logic [LINE_W-1:0] cur_line, next_line;
  logic [LINE_W-1:0] bottom_q, next_bottom;
  logic [COL_W-1:0]  left_q, next_left;
  logic [COL_W-1:0]  right_q, next_right;
  logic [2:0]        color_q, next_color;
  logic              swap_q, next_swap;
  logic [15:0]       next_data;
  logic [15:0]       next_count;
  logic              next_done, next_drop, next_ready;
  logic [LINE_W-1:0] bottom_clip, line_inc;
  logic [COL_W-1:0]  right_clip;

  // Write strobe follows q_full combinationally so a full queue never sees a write
  assign q_we = ((state == WORD0) || (state == WORD1)) && !q_full;

  // Next-state, datapath and registered-output computation
  always_comb begin
    next_state  = state;
    next_line   = cur_line;
    next_bottom = bottom_q;
    next_left   = left_q;
    next_right  = right_q;
    next_color  = color_q;
    next_swap   = swap_q;
    next_data   = q_data;
    next_count  = span_count;
    next_done   = 1'b0;
    next_drop   = 1'b0;
    bottom_clip = (req_bottom > LAST_LINE) ? LAST_LINE : req_bottom;
    right_clip  = (req_right > LAST_COL) ? LAST_COL : req_right;
    line_inc    = LINE_W'(cur_line + LINE_W'(1));

    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_swap) begin
            next_swap  = 1'b1;
            next_data  = SWAP_WORD0;
            next_state = WORD0;
          end else if ((req_top > bottom_clip) || (req_left > right_clip)) begin
            next_drop = 1'b1;
          end else begin
            next_swap   = 1'b0;
            next_line   = req_top;
            next_bottom = bottom_clip;
            next_left   = req_left;
            next_right  = right_clip;
            next_color  = req_color;
            next_data   = {1'b1, 7'(req_top), 8'(req_left)};
            next_state  = WORD0;
          end
        end
      end
      WORD0: begin
        if (!q_full) begin
          next_state = WORD1;
          next_data  = swap_q ? SWAP_WORD1 : {8'(right_q), 4'b0000, 1'b0, color_q};
        end
      end
      WORD1: begin
        if (!q_full) begin
          if (!swap_q) next_count = span_count + 16'd1;
          if (swap_q || (cur_line == bottom_q)) begin
            next_state = IDLE;
            next_done  = 1'b1;
          end else begin
            next_line  = line_inc;
            next_data  = {1'b1, 7'(line_inc), 8'(left_q)};
            next_state = WORD0;
          end
        end
      end
      default: next_state = IDLE;
    endcase

    next_ready = (next_state == IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur_line   <= '0;
      bottom_q   <= '0;
      left_q     <= '0;
      right_q    <= '0;
      color_q    <= '0;
      swap_q     <= 1'b0;
      q_data     <= 16'h0000;
      span_count <= 16'h0000;
      cmd_done   <= 1'b0;
      cmd_drop   <= 1'b0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= next_state;
      cur_line   <= next_line;
      bottom_q   <= next_bottom;
      left_q     <= next_left;
      right_q    <= next_right;
      color_q    <= next_color;
      swap_q     <= next_swap;
      q_data     <= next_data;
      span_count <= next_count;
      cmd_done   <= next_done;
      cmd_drop   <= next_drop;
      req_ready  <= next_ready;
      busy       <= !next_ready;
    end
  end

endmodule

// File: doc/draw_cmd_writer.md
Name: draw_cmd_writer

Overview:
- CPU-side producer for the painter command queue: accepts one rectangle-fill or buffer-swap request per handshake.
- Rasterises each rectangle into one horizontal span per line and writes each span as two 16-bit queue words, honouring the queue `full` back-pressure.
- Sits between the CPU store path and the draw unit's `we`/`data`/`full` interface, and relieves the CPU of per-line command generation and NOP-polling.

Parameters:
- LINES, 120, number of frame-buffer lines; valid line indices are 0..LINES-1.
- COLS, 160, pixels per line; valid column indices are 0..COLS-1.
- LINE_W, 7, width of line fields.
- COL_W, 8, width of column fields.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clock clk
- req_valid  in  1  CPU presents a request
- req_ready  out  1  block can accept a request
- req_swap  in  1  1 = buffer-swap request; rectangle fields are ignored
- req_top  in  LINE_W  first line of rectangle
- req_bottom  in  LINE_W  last line of rectangle, inclusive
- req_left  in  COL_W  first column
- req_right  in  COL_W  last column, inclusive
- req_color  in  3  {R,G,B}
- q_we  out  1  queue write enable
- q_data  out  16  queue word
- q_full  in  1  queue full; a word is not accepted while high
- busy  out  1  request in progress
- cmd_done  out  1  one-cycle pulse after the last word of a request is accepted
- cmd_drop  out  1  one-cycle pulse when a request is rejected as empty after clipping
- span_count  out  16  running count of span records written; wraps

Behaviour:
- Reset values: req_ready=1, q_we=0, q_data=0, busy=0, cmd_done=0, cmd_drop=0, span_count=0, state=IDLE.
- Handshake: a request is accepted on the rising edge where req_valid && req_ready; all fields are latched then. req_ready is 1 only in IDLE.
- Clipping, applied at accept:
  - bottom_c = min(req_bottom, LINES-1)
  - right_c = min(req_right, COLS-1)
  - if req_top > bottom_c or req_left > right_c: the request is dropped, cmd_drop pulses the next cycle, and the block stays in IDLE with no queue writes.
- Record format:
  - Span word0 = {1'b1, line[6:0], left[7:0]}
  - Span word1 = {right[7:0], 4'b0000, 1'b0, color[2:0]}
  - Swap word0 = 16'h0000
  - Swap word1 = {8'h00, 4'b0000, 1'b1, 3'b000}
- Queue write rule:
  - q_we = (state==WORD0 || state==WORD1) && !q_full, combinational on q_full.
  - q_data is registered and stable for the whole time the state is held.
  - A word is accepted on each edge where q_we=1. No word is ever written while q_full=1.
- States:
  - IDLE: on accept of a valid rectangle, cur_line <= req_top and go to WORD0. On accept of a swap, go to WORD0 with the swap flag set.
  - WORD0: hold until accepted, then go to WORD1.
  - WORD1: hold until accepted, then increment span_count (span records only; swap records are not counted). Then:
    - if swap, or cur_line == bottom_c: go to IDLE and pulse cmd_done on the cycle after the accepting edge.
    - otherwise: cur_line <= cur_line+1 and go to WORD0.
- busy = (state != IDLE).
- Latency:
  - First word is presented the cycle after accept.
  - With q_full=0 throughout, a rectangle of N lines takes exactly 2N cycles of q_we.
  - cmd_done pulses on cycle 2N+1 after accept.
- q_full may toggle on any cycle, including between word0 and word1. Words are never split, reordered or duplicated.
- req_valid asserted while busy has no effect; fields may change freely.
- Reset mid-request: the in-progress record is abandoned (a word0 without its word1 may be left in the queue; the draw unit is reset together with this block), state returns to IDLE and span_count returns to 0.
- Arithmetic: comparisons are unsigned; span_count wraps 16'hFFFF to 0.

Test Plan:
- Single span: top=bottom=5, left=10, right=20, color=3'b101, q_full=0 -> two words 16'h850A then 16'h1405 on consecutive cycles; cmd_done one cycle later; span_count=1.
- Rectangle: top=2, bottom=4, left=0, right=159, q_full=0 -> six words with lines 2,3,4 in order; q_we high for exactly 6 cycles; req_ready=0 until after cmd_done.
- Back-pressure: q_full asserted for 10 cycles after word0 of a 2-line rectangle is accepted -> q_we=0 and q_data held for those 10 cycles; then the remaining 3 words are written exactly once each.
- Clipping and drop: bottom=127, right=200 -> line fields stop at 119 and every word1 has right=159. top=50, bottom=40 -> cmd_drop pulse, zero queue writes, span_count unchanged.
- Swap: req_swap=1 -> words 16'h0000, 16'h0008; cmd_done pulses; span_count unchanged.
- Reset mid-request: reset asserted during line 3 of a 10-line rectangle -> next cycle q_we=0, req_ready=1, busy=0, span_count=0; a subsequent single-span request produces correct words.
